// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift unit: S1 registers and decodes the request, S2 holds the
// shifted result and its tag until the writeback side takes it.
module shift_exec_stage #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);
  // Handshake: a transfer happens on a cycle where valid & ready are both 1 at the
  // rising edge; valid never waits on ready, and held outputs do not change.
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_ROL = 3'd1;
  localparam logic [2:0] OP_SRL = 3'd2;
  localparam logic [2:0] OP_SRA = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  logic             s1_v_q, s1_v_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic [4:0]       s1_shamt_q, s1_shamt_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_v_q, s2_v_d;
  logic [31:0]      s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic        s2_free, s1_adv, in_fire, out_fire;
  logic [63:0] rot_l, rot_r;
  logic [31:0] shift_res;
  logic        shift_ill;

  always_comb begin
    s2_free  = !s2_v_q | out_ready;
    s1_adv   = s1_v_q & s2_free;
    in_ready = rst_n & (!s1_v_q | s2_free);
    in_fire  = in_valid & in_ready & !flush;
    out_fire = s2_v_q & out_ready;
  end

  // Rotates use a doubled operand so no shift ever reaches 32.
  always_comb begin
    rot_l     = {s1_data_q, s1_data_q} << s1_shamt_q;
    rot_r     = {s1_data_q, s1_data_q} >> s1_shamt_q;
    shift_res = s1_data_q;
    shift_ill = 1'b0;
    case (s1_op_q)
      OP_SLL:  shift_res = s1_data_q << s1_shamt_q;
      OP_ROL:  shift_res = rot_l[63:32];
      OP_SRL:  shift_res = s1_data_q >> s1_shamt_q;
      OP_SRA:  shift_res = $unsigned($signed(s1_data_q) >>> s1_shamt_q);
      OP_ROR:  shift_res = rot_r[31:0];
      default: shift_ill = 1'b1;
    endcase
  end

  always_comb begin
    s1_v_d       = s1_v_q;
    s1_data_d    = s1_data_q;
    s1_shamt_d   = s1_shamt_q;
    s1_op_d      = s1_op_q;
    s1_tag_d     = s1_tag_q;
    s2_v_d       = s2_v_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    s2_illegal_d = s2_illegal_q;
    done_d       = done_q;
    if (in_fire) begin
      s1_v_d     = 1'b1;
      s1_data_d  = in_data;
      s1_shamt_d = in_shamt;
      s1_op_d    = in_op;
      s1_tag_d   = in_tag;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
    if (s1_adv) begin
      s2_v_d       = 1'b1;
      s2_result_d  = shift_res;
      s2_tag_d     = s1_tag_q;
      s2_illegal_d = shift_ill;
    end else if (out_fire) begin
      s2_v_d = 1'b0;
    end
    // Flush kills only the valid bits; a handshake in the same cycle still counts.
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
    if (out_fire) done_d = done_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q       <= 1'b0;
      s1_data_q    <= '0;
      s1_shamt_q   <= '0;
      s1_op_q      <= '0;
      s1_tag_q     <= '0;
      s2_v_q       <= 1'b0;
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
      s2_illegal_q <= 1'b0;
      done_q       <= '0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_data_q    <= s1_data_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_op_q      <= s1_op_d;
      s1_tag_q     <= s1_tag_d;
      s2_v_q       <= s2_v_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
      s2_illegal_q <= s2_illegal_d;
      done_q       <= done_d;
    end
  end

  assign out_valid   = s2_v_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_illegal = s2_illegal_q;
  assign busy        = s1_v_q | s2_v_q;
  assign done_count  = done_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: vector table through a scoreboard queue, plus
// backpressure, flush, mid-stream reset and 4-bit counter wrap sequences.
module tb_shift_exec_stage;
  localparam int TW = 5;
  localparam int CW = 4;
  localparam int W  = 32 + TW + 1;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
  logic [31:0]   in_data, out_result;
  logic [4:0]    in_shamt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;
  logic [CW-1:0] done_count;

  shift_exec_stage #(.TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]  exp_q[$];
  int            acc_q[$];
  logic [CW-1:0] exp_cnt = '0;
  logic [31:0]   drv_res = '0;
  logic          drv_ill = 1'b0;
  logic          chk_lat = 1'b0;
  logic          hold_v = 1'b0;
  logic [W-1:0]  hold_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [2:0] op);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (op)
        3'd0: r[i] = (i >= s) ? d[i-s] : 1'b0;
        3'd1: r[i] = d[(i - s + 32) % 32];
        3'd2: r[i] = (i + s <= 31) ? d[i+s] : 1'b0;
        3'd3: r[i] = (i + s <= 31) ? d[i+s] : d[31];
        3'd4: r[i] = d[(i + s) % 32];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Scoreboard and monitor, sampled on the falling edge while everything is stable.
  always @(negedge clk) begin
    logic [W-1:0] e;
    int a;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      exp_cnt = '0;
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid)
        check("held_output", {out_result, out_tag, out_illegal}, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {out_result, out_tag, out_illegal}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_result", out_result, e[W-1:TW+1]);
          check("out_tag", out_tag, e[TW:1]);
          check("out_illegal", out_illegal, e[0]);
          if (chk_lat) check("latency", 64'(cyc - a), 64'd2);
        end
        exp_cnt = exp_cnt + 1'b1;
      end
      hold_v = out_valid && !out_ready;
      hold_val = {out_result, out_tag, out_illegal};
      if (flush) begin
        exp_q.delete();
        acc_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back({drv_res, in_tag, drv_ill});
        acc_q.push_back(cyc);
      end
    end
  end

  // Drivers: called just after a rising edge; return just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [2:0] op,
                      input logic [TW-1:0] tag, input logic [31:0] er, input logic ei);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op; in_tag = tag;
    drv_res = er; drv_ill = ei;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (n >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done_count", done_count, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_illegal", out_illegal, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [31:0]   data;
    logic [4:0]    shamt;
    logic [2:0]    op;
    logic [TW-1:0] tag;
    logic [31:0]   exp_res;
    logic          exp_ill;
  } vec_t;
  localparam int NV = 20;
  vec_t vtab[NV];

  initial begin
    logic [31:0] d;
    logic [4:0]  s;
    logic [2:0]  op;
    logic        acc;
    int          ops;
    vtab[0]  = '{32'h8000_0000, 5'd4,  3'd3, 5'd1,  32'hF800_0000, 1'b0};
    vtab[1]  = '{32'h8000_0000, 5'd4,  3'd2, 5'd2,  32'h0800_0000, 1'b0};
    vtab[2]  = '{32'h0000_0001, 5'd31, 3'd0, 5'd3,  32'h8000_0000, 1'b0};
    vtab[3]  = '{32'h8000_0001, 5'd1,  3'd1, 5'd4,  32'h0000_0003, 1'b0};
    vtab[4]  = '{32'h0000_0001, 5'd1,  3'd4, 5'd5,  32'h8000_0000, 1'b0};
    vtab[5]  = '{32'hDEAD_BEEF, 5'd0,  3'd0, 5'd6,  32'hDEAD_BEEF, 1'b0};
    vtab[6]  = '{32'hDEAD_BEEF, 5'd0,  3'd1, 5'd7,  32'hDEAD_BEEF, 1'b0};
    vtab[7]  = '{32'hDEAD_BEEF, 5'd0,  3'd2, 5'd8,  32'hDEAD_BEEF, 1'b0};
    vtab[8]  = '{32'hDEAD_BEEF, 5'd0,  3'd3, 5'd9,  32'hDEAD_BEEF, 1'b0};
    vtab[9]  = '{32'hDEAD_BEEF, 5'd0,  3'd4, 5'd10, 32'hDEAD_BEEF, 1'b0};
    vtab[10] = '{32'h1234_5678, 5'd3,  3'd6, 5'd7,  32'h1234_5678, 1'b1};
    vtab[11] = '{32'hA5A5_A5A5, 5'd7,  3'd5, 5'd11, 32'hA5A5_A5A5, 1'b1};
    vtab[12] = '{32'h0F0F_0F0F, 5'd0,  3'd7, 5'd12, 32'h0F0F_0F0F, 1'b1};
    vtab[13] = '{32'h1234_5678, 5'd8,  3'd1, 5'd13, 32'h3456_7812, 1'b0};
    vtab[14] = '{32'h1234_5678, 5'd4,  3'd4, 5'd14, 32'h8123_4567, 1'b0};
    vtab[15] = '{32'h7FFF_FFFF, 5'd31, 3'd3, 5'd15, 32'h0000_0000, 1'b0};
    vtab[16] = '{32'hFFFF_0000, 5'd16, 3'd3, 5'd16, 32'hFFFF_FFFF, 1'b0};
    vtab[17] = '{32'h8000_0000, 5'd31, 3'd4, 5'd17, 32'h0000_0001, 1'b0};
    vtab[18] = '{32'h0000_0001, 5'd31, 3'd1, 5'd18, 32'h8000_0000, 1'b0};
    vtab[19] = '{32'hF000_0000, 5'd28, 3'd2, 5'd19, 32'h0000_000F, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    #12;
    check("init_out_valid", out_valid, 0);
    check("init_in_ready", in_ready, 0);
    check("init_done_count", done_count, 0);
    check("init_busy", busy, 0);
    check("init_out_result", out_result, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_in_ready", in_ready, 1);

    // Vector sweep, full throughput, fixed two-cycle latency.
    chk_lat = 1'b1;
    for (int i = 0; i < NV; i++)
      send(vtab[i].data, vtab[i].shamt, vtab[i].op, vtab[i].tag, vtab[i].exp_res, vtab[i].exp_ill);
    wait_empty();
    chk_lat = 1'b0;
    check("sweep_done_count", done_count, 64'(NV % 16));

    // Random ops with random backpressure.
    ops = 0;
    for (int c = 0; c < 150; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && ops < 40) begin
        d = $urandom; s = 5'($urandom_range(0, 31)); op = 3'($urandom_range(0, 7));
        in_data = d; in_shamt = s; in_op = op; in_tag = TW'($urandom_range(0, 31));
        drv_res = ref_shift(d, int'(s), op); drv_ill = (op > 3'd4);
        in_valid = 1'b1; ops++;
      end
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_empty();
    check("random_done_count", done_count, exp_cnt);

    // Backpressure: two accepted, third stalls, outputs held, then drain in order.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'h0000_0011 << k; in_shamt = 5'd1; in_op = 3'd0;
      in_tag = TW'(20 + k); drv_res = 32'h0000_0022 << k; drv_ill = 1'b0;
      @(negedge clk);
      check("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
      if (k < 2) begin @(posedge clk); #1; end
    end
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_head_result", out_result, 32'h0000_0022);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(32'h0000_0044, 5'd1, 3'd0, TW'(22), 32'h0000_0088, 1'b0);
    send(32'h0000_0088, 5'd1, 3'd0, TW'(23), 32'h0000_0110, 1'b0);
    wait_empty();
    check("bp_done_count", done_count, 64'((NV + ops + 4) % 16));

    // Flush with both stages full and a new input offered, no output handshake.
    out_ready = 1'b0;
    send(32'h1111_1111, 5'd2, 3'd1, TW'(1), 32'h4444_4444, 1'b0);
    send(32'h2222_2222, 5'd2, 3'd1, TW'(2), 32'h8888_8888, 1'b0);
    in_valid = 1'b1; in_data = 32'h3333_3333; in_tag = TW'(3); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("flush_no_leak_busy", busy, 0);
    @(posedge clk); #1;

    // Flush coinciding with an output handshake: that transfer is counted.
    out_ready = 1'b0;
    send(32'h0000_00F0, 5'd4, 3'd2, TW'(4), 32'h0000_000F, 1'b0);
    send(32'h0000_00F0, 5'd4, 3'd0, TW'(5), 32'h0000_0F00, 1'b0);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'h5555_5555;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush2_out_valid", out_valid, 0);
    check("flush2_done_count", done_count, exp_cnt);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;

    // Reset mid-stream with both stages full.
    out_ready = 1'b0;
    send(32'hCAFE_0001, 5'd0, 3'd0, TW'(9), 32'hCAFE_0001, 1'b0);
    send(32'hCAFE_0002, 5'd0, 3'd0, TW'(10), 32'hCAFE_0002, 1'b0);
    pulse_reset();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", out_valid, 0);
    @(posedge clk); #1;
    send(32'h0000_0003, 5'd1, 3'd4, TW'(30), 32'h8000_0001, 1'b0);
    wait_empty();
    check("post_rst_done_count", done_count, 1);

    // Counter wrap on the 4-bit instance.
    pulse_reset();
    for (int i = 0; i < 17; i++)
      send(32'(i), 5'd1, 3'd0, TW'(i), 32'(i) << 1, 1'b0);
    wait_empty();
    check("wrap_done_count", done_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
